dir_button_encoder: RTL and testbench
=====================================

// Module: dir_button_encoder
// PURPOSE
//  - Front end of the player-input path. Synchronises and debounces the four raw direction
//    push-buttons, then arbitrates them into one 2-bit direction code plus a held flag.
//  - Feeds the LED one-hot display stage, which expects num[1:0] and pressed.
//  - Feeds game logic via a one-cycle press pulse.
// PARAMETERS
//  - DEBOUNCE_CYCLES  500000    stable cycles required to accept a level change (5 ms @ 100 MHz); >=2
//  - REPEAT_CYCLES    25000000  auto-repeat period while a direction is held (BTN_REPEAT_EN only); >=2
//  - CNT_W            $clog2(max(DEBOUNCE_CYCLES,REPEAT_CYCLES))+1  counter width, derived, do not override
// PORTS
//  - clk          in   1  system clock
//  - rst          in   1  asynchronous, active-high reset
//  - btn_raw      in   4  raw buttons, active-high, asynchronous to clk: [0]=up [1]=right [2]=down [3]=left
//  - num          out  2  selected direction index (0..3 = btn_raw bit), holds last value when released
//  - pressed      out  1  high while the selected direction is debounced-held
//  - press_pulse  out  1  one-cycle strobe on each newly selected direction (and on repeats)
// BEHAVIOUR
//  - One clock, clk. Reset is asynchronous and active-high on rst. All flops clear on rst assertion.
//  - Reset values: num=0, pressed=0, press_pulse=0; sync flops=0, stable=0, counters=0, FSM=IDLE.
//  - Sync: 2-flop synchroniser per button. Only sync2[i] is used downstream.
//  - Debounce, per button:
//    - cnt clears whenever sync2[i]==stable[i].
//    - Otherwise cnt increments. stable[i] toggles, and cnt clears, on the edge where cnt==DEBOUNCE_CYCLES-1.
//    - Any bounce back before that restarts the count; pulses shorter than DEBOUNCE_CYCLES are never seen.
//  - Latency: a clean raw edge reaches pressed/num DEBOUNCE_CYCLES+3 clk edges later
//    (2 sync + DEBOUNCE_CYCLES + 1 output register). Release has the same latency.
//  - Arbiter FSM (registered outputs):
//    - IDLE: no stable button.
//      - If any stable[i]: num<=lowest set i, pressed<=1, press_pulse<=1, go to ACTIVE.
//    - ACTIVE: num is locked to the captured button. New presses of other buttons are ignored.
//      - Captured button releases and others are stable: num<=lowest other stable i, press_pulse<=1, stay ACTIVE.
//      - Captured button releases and none are stable: pressed<=0, num holds, go to IDLE.
//  - Simultaneous acceptance of several buttons in one cycle: lowest index wins.
//  - press_pulse is high for exactly one cycle, never two back-to-back without an intervening event.
//  - Reset mid-debounce or mid-hold: all state cleared. A button still held at rst release
//    must re-debounce fully (DEBOUNCE_CYCLES+3) before pressed rises.
// CONFIGURATION
//  - BTN_REPEAT_EN defined:
//    - In ACTIVE, a repeat counter clears on each capture/switch.
//    - It raises press_pulse for one cycle every REPEAT_CYCLES cycles while the captured button stays held.
//    - The counter clears on entering IDLE.
//  - BTN_REPEAT_EN undefined: no repeat counter is built; press_pulse fires only on capture/switch.
//  - num and pressed are identical in both builds.
// STRUCTURE
//  - Shared package pacman_input_pkg:
//    - NUM_BTNS=4, DIR_W=2
//    - DIR_UP=2'd0, DIR_RIGHT=2'd1, DIR_DOWN=2'd2, DIR_LEFT=2'd3
//    - FSM state typedef {IDLE, ACTIVE}
//  - Sub-module btn_debounce (sync + counter + stable flop, parameter DEBOUNCE_CYCLES):
//    - instantiated 4x via generate.
//  - Top level holds only the arbiter FSM and the optional repeat counter.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
//  - Reset: assert rst mid-cycle with btn_raw=4'b0010 held.
//    -> outputs 0 immediately (async).
//    -> after release, pressed=1, num=1 exactly 7 edges later; press_pulse one cycle.
//  - Bounce: btn_raw[2] toggles 1,0,1 with 2-cycle widths, then holds 1.
//    -> a single press_pulse, num=2, 7 edges after the final rising edge. No earlier activity.
//  - Glitch: btn_raw[3] high for 3 cycles only.
//    -> pressed stays 0, press_pulse never fires.
//  - Simultaneous: btn_raw 0000 -> 1010 in one cycle.
//    -> num=1, then on release of bit1 only: num=3, press_pulse one cycle, pressed stays 1.
//  - Lock/release: hold bit0, then add bit2.
//    -> num stays 0. Drop both -> pressed=0 after 7 edges, num holds 0.
//  - BTN_REPEAT_EN: hold bit1 for 30 cycles after capture.
//    -> press_pulse at capture, then every 8 cycles. Undefined build -> only the capture pulse.

Source files
------------

// File: rtl/pacman_input_pkg.sv
// Shared definitions for the player-input path: button count, direction codes,
// arbiter state type and a lowest-set-bit helper used by the arbiter.
package pacman_input_pkg;

    localparam int unsigned NUM_BTNS = 4;
    localparam int unsigned DIR_W    = 2;

    localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd1;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd2;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 when none are set.
    function automatic logic [DIR_W-1:0] lowest_set(input logic [NUM_BTNS-1:0] v);
        logic [DIR_W-1:0] r;
        r = DIR_UP;
        for (int i = int'(NUM_BTNS) - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = DIR_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button synchroniser and debouncer.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   raw    in  raw button level, asynchronous to clk
//   stable out debounced level; toggles after DEBOUNCE_CYCLES consecutive
//              cycles of the synchronised input disagreeing with it
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser, disagreement counter and accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dir_button_encoder.sv
// Direction button encoder: debounces four direction buttons and arbitrates them
// into a 2-bit direction code, a held flag and a one-cycle press strobe.
// Optional feature macro: BTN_REPEAT_EN adds an auto-repeat strobe every
// REPEAT_CYCLES cycles while the captured direction stays held.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   btn_raw     in   [0]=up [1]=right [2]=down [3]=left, active-high, async
//   num         out  selected direction index, holds last value on release
//   pressed     out  high while the selected direction is debounced-held
//   press_pulse out  one-cycle strobe on capture/switch (and repeats)
module dir_button_encoder
    import pacman_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       btn_raw,
    output logic [DIR_W-1:0] num,
    output logic             pressed,
    output logic             press_pulse
);

    localparam int unsigned CNT_W =
        $clog2((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES) + 1;

    logic [NUM_BTNS-1:0] stable;

    state_t           state;
    state_t           state_nxt;
    logic [DIR_W-1:0] num_nxt;
    logic             pressed_nxt;
    logic             pulse_nxt;

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .raw    (btn_raw[gi]),
            .stable (stable[gi])
        );
    end

`ifdef BTN_REPEAT_EN
    logic [CNT_W-1:0] rpt;
    logic [CNT_W-1:0] rpt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt <= '0;
        end else begin
            rpt <= rpt_nxt;
        end
    end
`endif

    // Arbiter state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            num         <= DIR_UP;
            pressed     <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            num         <= num_nxt;
            pressed     <= pressed_nxt;
            press_pulse <= pulse_nxt;
        end
    end

    // Next-state: capture lowest stable button, lock until it releases.
    always_comb begin
        state_nxt   = state;
        num_nxt     = num;
        pressed_nxt = pressed;
        pulse_nxt   = 1'b0;
`ifdef BTN_REPEAT_EN
        rpt_nxt     = rpt;
`endif
        case (state)
            IDLE: begin
                if (|stable) begin
                    num_nxt     = lowest_set(stable);
                    pressed_nxt = 1'b1;
                    pulse_nxt   = 1'b1;
                    state_nxt   = ACTIVE;
`ifdef BTN_REPEAT_EN
                    rpt_nxt     = '0;
`endif
                end
            end
            ACTIVE: begin
                if (!stable[num]) begin
                    // Captured button released: hand over or go idle.
                    if (|stable) begin
                        num_nxt   = lowest_set(stable);
                        pulse_nxt = 1'b1;
                    end else begin
                        pressed_nxt = 1'b0;
                        state_nxt   = IDLE;
                    end
`ifdef BTN_REPEAT_EN
                    rpt_nxt = '0;
`endif
                end else begin
`ifdef BTN_REPEAT_EN
                    if (rpt == CNT_W'(REPEAT_CYCLES - 1)) begin
                        pulse_nxt = 1'b1;
                        rpt_nxt   = '0;
                    end else begin
                        rpt_nxt = rpt + CNT_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dir_button_encoder.sv
// Self-checking bench for dir_button_encoder (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
// Directed scenarios followed by random button activity, all checked each cycle
// against a history-window reference model. Honours BTN_REPEAT_EN.
module tb_dir_button_encoder;

    localparam int unsigned D = 4;
    localparam int unsigned R = 8;
`ifdef BTN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'b0;
    logic [1:0] num;
    logic       pressed;
    logic       press_pulse;

    always #5 clk = ~clk;

    dir_button_encoder #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .num         (num),
        .pressed     (pressed),
        .press_pulse (press_pulse)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         n;
    logic [3:0] hist[$];
    logic [3:0] m_stable;
    bit         m_active;
    logic [1:0] m_num;
    logic       m_pressed;
    logic       m_pulse;
    int         cap;

    int pulse_cnt;
    bit seen_pressed;
    int first;
    bit all_held;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raw level sampled at clock edge k after reset release (sync flops read 0 before).
    function automatic logic [3:0] sample(input int k);
        if (k >= 1) return hist[k-1];
        return 4'b0;
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        int r;
        r = 0;
        while (r < 3 && !v[r]) r++;
        return 2'(r);
    endfunction

    task automatic model_reset();
        n = 0;
        hist.delete();
        m_stable  = 4'b0;
        m_active  = 1'b0;
        m_num     = 2'd0;
        m_pressed = 1'b0;
        m_pulse   = 1'b0;
        cap       = 0;
    endtask

    // A button's accepted level flips once the D raw samples taken at edges
    // n-D-1..n-2 all disagree with it; outputs follow the accepted levels one edge later.
    task automatic model_edge();
        logic [3:0] s_old;
        logic [3:0] smp;
        bit         all_diff;
        s_old = m_stable;
        n++;
        hist.push_back(btn_raw);
        m_pulse = 1'b0;
        if (!m_active) begin
            if (s_old != 4'b0) begin
                m_num     = low_idx(s_old);
                m_pressed = 1'b1;
                m_pulse   = 1'b1;
                m_active  = 1'b1;
                cap       = n;
            end
        end else if (!s_old[m_num]) begin
            if (s_old != 4'b0) begin
                m_num   = low_idx(s_old);
                m_pulse = 1'b1;
                cap     = n;
            end else begin
                m_pressed = 1'b0;
                m_active  = 1'b0;
            end
        end else if (REP && ((n - cap) % int'(R) == 0)) begin
            m_pulse = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int k = n - int'(D) - 1; k <= n - 2; k++) begin
                smp = sample(k);
                if (smp[i] == m_stable[i]) all_diff = 1'b0;
            end
            if (all_diff) m_stable[i] = ~m_stable[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("num", 8'(num), 8'(m_num));
        chk("pressed", 8'(pressed), 8'(m_pressed));
        chk("press_pulse", 8'(press_pulse), 8'(m_pulse));
        if (press_pulse) pulse_cnt++;
        if (pressed) seen_pressed = 1'b1;
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    // Assert reset mid-cycle, confirm async clear, release on a falling edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_num", 8'(num), 8'h0);
        chk("rst_pressed", 8'(pressed), 8'h0);
        chk("rst_pulse", 8'(press_pulse), 8'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        pulse_cnt    = 0;
        seen_pressed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_num", 8'(num), 8'h0);
        chk("init_pressed", 8'(pressed), 8'h0);
        chk("init_pulse", 8'(press_pulse), 8'h0);
        @(negedge clk);
        rst = 1'b0;
        run(3);

        // Reset while right is captured and still held: must re-debounce.
        btn_raw = 4'b0010;
        run(10);
        do_reset();
        pulse_cnt = 0;
        first = -1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (pressed && first < 0) first = t;
        end
        chk("rst_latency", 8'(first), 8'd7);
        chk("rst_num_after", 8'(num), 8'd1);
        chk("rst_pulse_count", 8'(pulse_cnt), 8'd1);
        btn_raw = 4'b0;
        run(10);

        // Bounce on down, then steady hold.
        btn_raw = 4'b0100; run(2);
        btn_raw = 4'b0000; run(2);
        btn_raw = 4'b0100;
        pulse_cnt = 0;
        first = -1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (press_pulse && first < 0) first = t;
        end
        chk("bounce_pulse_edge", 8'(first), 8'd7);
        chk("bounce_pulse_count", 8'(pulse_cnt), 8'd1);
        chk("bounce_num", 8'(num), 8'd2);
        btn_raw = 4'b0;
        run(10);

        // Short glitch on left is never accepted.
        pulse_cnt = 0;
        seen_pressed = 1'b0;
        btn_raw = 4'b1000; run(3);
        btn_raw = 4'b0000; run(12);
        chk("glitch_pressed", 8'(seen_pressed), 8'd0);
        chk("glitch_pulse", 8'(pulse_cnt), 8'd0);

        // Simultaneous right+left: right wins, left takes over on release.
        btn_raw = 4'b1010;
        run(10);
        chk("simul_num", 8'(num), 8'd1);
        pulse_cnt = 0;
        all_held = 1'b1;
        btn_raw = 4'b1000;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (!pressed) all_held = 1'b0;
        end
        chk("switch_num", 8'(num), 8'd3);
        chk("switch_pulse_count", 8'(pulse_cnt), 8'd1);
        chk("switch_held", 8'(all_held), 8'd1);
        btn_raw = 4'b0;
        run(10);

        // Lock on up, ignore added down, then release both.
        btn_raw = 4'b0001; run(10);
        btn_raw = 4'b0101; run(10);
        chk("lock_num", 8'(num), 8'd0);
        btn_raw = 4'b0000;
        first = -1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (!pressed && first < 0) first = t;
        end
        chk("release_latency", 8'(first), 8'd7);
        chk("release_num", 8'(num), 8'd0);

        // Long hold: capture pulse, then repeats only in the repeat build.
        btn_raw = 4'b0010;
        run(7);
        chk("hold_capture_pulse", 8'(press_pulse), 8'd1);
        pulse_cnt = 0;
        run(30);
        chk("hold_repeat_count", 8'(pulse_cnt), REP ? 8'd3 : 8'd0);
        btn_raw = 4'b0;
        run(10);

        // Random activity with mixed hold lengths around the debounce window.
        repeat (80) begin
            btn_raw = 4'($urandom_range(0, 15));
            run(int'($urandom_range(1, 9)));
        end
        btn_raw = 4'b0;
        run(12);
        chk("final_pressed", 8'(pressed), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
